// File: rtl/branch_predictor_gshare_param_if.sv
// rtl/branch_predictor_gshare_param_if.sv - resolved-branch update bus from the branch stage
interface branch_predictor_gshare_param_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 6
);
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic [GHR_W-1:0] upd_ghr;
  logic [PC_W-1:0]  upd_pred_next;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_pred_next
  );
  modport slave (
    input upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_pred_next
  );
endinterface

// File: rtl/branch_predictor_gshare_param.sv
// rtl/branch_predictor_gshare_param.sv - gshare direction predictor with BTB and fetch PC generation
module branch_predictor_gshare_param #(
  parameter int PC_W         = 32,
  parameter int FETCH_STRIDE = 8,
  parameter int BTB_IDX_W    = 6,
  parameter int TAG_W        = 10,
  parameter int GHR_W        = 6,
  parameter int PHT_IDX_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall,
  branch_predictor_gshare_param_if.slave       upd,
  output logic [PC_W-1:0]                      pc,
  output logic                                 pred_taken,
  output logic [GHR_W-1:0]                     pred_ghr,
  output logic                                 flush,
  output logic                                 ready,
  output logic [31:0]                          br_count,
  output logic [31:0]                          mis_count
);
  localparam int OFF   = $clog2(FETCH_STRIDE);
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int SWP_W = (BTB_IDX_W > PHT_IDX_W) ? BTB_IDX_W : PHT_IDX_W;
  localparam logic [SWP_W-1:0] SWP_LAST = '1;
  localparam logic [PC_W-1:0]  STRIDE   = PC_W'(FETCH_STRIDE);

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state_q, state_d;

  logic [SWP_W-1:0] swp_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [PC_W-1:0]  btb_target [BTB_N];
  logic [1:0]       pht        [PHT_N];

  logic [BTB_IDX_W-1:0] f_slot, u_slot;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [PHT_IDX_W-1:0] f_pidx, u_pidx;
  logic [1:0]           f_ctr, u_ctr, u_ctr_n;
  logic                 btb_hit;
  logic [PC_W-1:0]      correct_next;

  // Fetch-side lookup reads the arrays combinationally, so same-cycle updates land one cycle later
  assign f_slot  = pc_q[OFF +: BTB_IDX_W];
  assign f_tag   = pc_q[OFF + BTB_IDX_W +: TAG_W];
  assign f_pidx  = pc_q[OFF +: PHT_IDX_W] ^ PHT_IDX_W'(ghr_q);
  assign f_ctr   = pht[f_pidx];
  assign btb_hit = btb_valid[f_slot] && (btb_tag[f_slot] == f_tag);

  assign u_slot  = upd.upd_pc[OFF +: BTB_IDX_W];
  assign u_tag   = upd.upd_pc[OFF + BTB_IDX_W +: TAG_W];
  assign u_pidx  = upd.upd_pc[OFF +: PHT_IDX_W] ^ PHT_IDX_W'(upd.upd_ghr);
  assign u_ctr   = pht[u_pidx];
  assign u_ctr_n = upd.upd_taken ? ((u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'b01)
                                 : ((u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'b01);

  assign correct_next = upd.upd_taken ? upd.upd_target : upd.upd_pc + STRIDE;

  assign pc       = pc_q;
  assign pred_ghr = ghr_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    pred_taken = 1'b0;
    flush      = 1'b0;
    pc_d       = pc_q;
    ghr_d      = ghr_q;
    case (state_q)
      S_INIT: begin
        pc_d  = '0;
        ghr_d = '0;
        if (swp_q == SWP_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        ready      = 1'b1;
        pred_taken = btb_hit && f_ctr[1];
        flush      = upd.upd_valid && (correct_next != upd.upd_pred_next);
        if (flush) begin
          pc_d  = correct_next;
          ghr_d = {upd.upd_ghr[GHR_W-2:0], upd.upd_taken};
        end else if (!stall) begin
          pc_d = pred_taken ? btb_target[f_slot] : pc_q + STRIDE;
          if (btb_hit) ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      swp_q     <= '0;
      pc_q      <= '0;
      ghr_q     <= '0;
      br_count  <= '0;
      mis_count <= '0;
    end else begin
      swp_q <= (state_q == S_INIT) ? swp_q + SWP_W'(1) : '0;
      pc_q  <= pc_d;
      ghr_q <= ghr_d;
      if (state_q == S_RUN && upd.upd_valid && br_count != '1) br_count <= br_count + 32'd1;
      if (flush && mis_count != '1) mis_count <= mis_count + 32'd1;
    end
  end

  // Tables carry no reset; the INIT sweep is what makes them consistent
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == S_INIT) begin
        if ((swp_q >> BTB_IDX_W) == '0) btb_valid[swp_q[BTB_IDX_W-1:0]] <= 1'b0;
        if ((swp_q >> PHT_IDX_W) == '0) pht[swp_q[PHT_IDX_W-1:0]] <= 2'b01;
      end else if (upd.upd_valid) begin
        pht[u_pidx] <= u_ctr_n;
        if (upd.upd_taken) begin
          btb_valid[u_slot]  <= 1'b1;
          btb_tag[u_slot]    <= u_tag;
          btb_target[u_slot] <= upd.upd_target;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare_param.sv
// tb/tb_branch_predictor_gshare_param.sv - directed self-checking bench for branch_predictor_gshare_param
module tb_branch_predictor_gshare_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic        pred_taken;
  logic [5:0]  pred_ghr;
  logic        flush;
  logic        ready;
  logic [31:0] br_count;
  logic [31:0] mis_count;
  int          checks = 0;
  int          failures = 0;
  int          n;

  always #5 clk = ~clk;

  branch_predictor_gshare_param_if #(.PC_W(32), .GHR_W(6)) bus ();

  branch_predictor_gshare_param u_dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .upd       (bus.slave),
    .pc        (pc),
    .pred_taken(pred_taken),
    .pred_ghr  (pred_ghr),
    .flush     (flush),
    .ready     (ready),
    .br_count  (br_count),
    .mis_count (mis_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                      input logic [5:0] g, input logic [31:0] pn);
    bus.upd_valid     = 1'b1;
    bus.upd_pc        = p;
    bus.upd_taken     = t;
    bus.upd_target    = tgt;
    bus.upd_ghr       = g;
    bus.upd_pred_next = pn;
    #1;
  endtask

  task automatic idle();
    bus.upd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.upd_ghr = '0; bus.upd_pred_next = '0;

    // Reset and initialisation sweep
    tick();
    check("rst_ready", ready, 0);
    check("rst_pc", pc, 0);
    check("rst_br", br_count, 0);
    check("rst_mis", mis_count, 0);
    check("rst_pred", pred_taken, 0);
    reset = 1'b1;
    wait_ready(n);
    check("init_cycles", n, 256);
    check("run_pc0", pc, 0);
    check("run_ghr0", pred_ghr, 0);
    tick(); check("run_pc8", pc, 32'h8);
    tick(); check("run_pc16", pc, 32'h10);

    // Mispredicted taken branch at 0x40
    send(32'h40, 1'b1, 32'h100, 6'd0, 32'h48);
    check("flush_040", flush, 1);
    tick(); idle();
    check("pc_after_flush", pc, 32'h100);
    check("mis_1", mis_count, 1);
    check("br_1", br_count, 1);
    check("ghr_repair", pred_ghr, 6'b000001);

    // Second taken resolve, correctly predicted
    send(32'h40, 1'b1, 32'h100, 6'd0, 32'h100);
    check("noflush_041", flush, 0);
    tick(); idle();
    check("br_2", br_count, 2);
    check("mis_still_1", mis_count, 1);

    // Redirect to 0x40 with GHR=0 and observe the prediction
    send(32'h38, 1'b0, 32'h0, 6'd0, 32'h0);
    check("flush_038", flush, 1);
    tick(); idle();
    check("pc_040", pc, 32'h40);
    check("ghr_0", pred_ghr, 0);
    check("pred_040", pred_taken, 1);
    tick();
    check("pc_pred_target", pc, 32'h100);
    check("ghr_spec", pred_ghr, 6'b000001);

    // Stall hold
    send(32'h200, 1'b1, 32'h80, 6'd0, 32'h0);
    tick(); idle();
    check("pc_080", pc, 32'h80);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h80);
      check("stall_ghr", pred_ghr, 6'b000001);
    end
    // Flush beats stall
    send(32'h300, 1'b0, 32'h0, 6'b000011, 32'h0);
    check("flush_stall", flush, 1);
    tick();
    stall = 1'b0;
    idle();
    check("flush_wins_pc", pc, 32'h308);
    check("flush_wins_ghr", pred_ghr, 6'b000110);

    // Saturation at 11: one more taken at index 8
    send(32'h40, 1'b1, 32'h100, 6'd0, 32'h100);
    check("noflush_sat11", flush, 0);
    tick(); idle();
    // Redirect to 0x40 (also drives index 7 not-taken while already 00)
    send(32'h38, 1'b0, 32'h0, 6'd0, 32'h0);
    tick(); idle();
    check("pc_040b", pc, 32'h40);
    check("sat11_pred", pred_taken, 1);
    tick();
    check("pc_100b", pc, 32'h100);

    // Saturation at 00: one taken at index 7 should yield 01 (not taken)
    send(32'h38, 1'b1, 32'h500, 6'd0, 32'h500);
    check("noflush_038t", flush, 0);
    tick(); idle();
    send(32'h30, 1'b0, 32'h0, 6'd0, 32'h0);
    tick(); idle();
    check("pc_038", pc, 32'h38);
    check("sat00_pred", pred_taken, 0);
    tick();
    check("pc_040c", pc, 32'h40);
    check("ghr_shift0", pred_ghr, 0);
    check("pred_040c", pred_taken, 1);

    // PC wrap
    send(32'hFFFF_FFF0, 1'b0, 32'h0, 6'd0, 32'h0);
    tick(); idle();
    check("pc_top", pc, 32'hFFFF_FFF8);
    check("pred_top", pred_taken, 0);
    tick();
    check("pc_wrap", pc, 32'h0);
    check("br_total", br_count, 10);
    check("mis_total", mis_count, 7);

    // Mid-operation reset, then reset again mid-sweep at index 100
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst2_ready", ready, 0);
    check("rst2_pc", pc, 0);
    check("rst2_br", br_count, 0);
    check("rst2_mis", mis_count, 0);
    check("rst2_ghr", pred_ghr, 0);
    repeat (50) tick();
    send(32'h40, 1'b1, 32'h100, 6'd0, 32'h48);
    check("init_noflush", flush, 0);
    repeat (50) tick();
    idle();
    check("init_br_ignored", br_count, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_ready(n);
    check("init_restart_cycles", n, 256);
    check("rerun_pc0", pc, 0);
    send(32'h38, 1'b0, 32'h0, 6'd0, 32'h0);
    tick(); idle();
    check("rerun_pc040", pc, 32'h40);
    check("rerun_btb_clear", pred_taken, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
